// File: rtl/ifq_pkg.sv
`default_nettype none
// ============================================================================
// Module : ifq_pkg
// Brief  : Shared defaults and word/address types for the wide fetch queue.
// Rev    : 1.0
// ============================================================================
package ifq_pkg;
  localparam int          c_LINE_WORDS = 4;
  localparam int          c_DEPTH      = 4;
  localparam int          c_ISSUE      = 2;
  localparam logic [31:0] c_RESET_PC   = 32'h0040_0000;

  typedef logic [31:0] word_t;
  typedef logic [31:0] addr_t;
endpackage
`default_nettype wire

// File: rtl/ifq_line_buf.sv
`default_nettype none
// ============================================================================
// Module : ifq_line_buf
// Brief  : Line storage with one line write port and ISSUE word read ports.
// Rev    : 1.0
// ============================================================================
module ifq_line_buf
  import ifq_pkg::*;
#(
  parameter int LINE_WORDS = c_LINE_WORDS,
  parameter int DEPTH      = c_DEPTH,
  parameter int ISSUE      = c_ISSUE,
  localparam int c_WB      = $clog2(LINE_WORDS),
  localparam int c_LB      = $clog2(DEPTH),
  localparam int c_PW      = c_LB + c_WB
)(
  input  logic                    clk,
  input  logic                    i_wr_en,
  input  logic [c_LB-1:0]         i_wr_line,
  input  logic [32*LINE_WORDS-1:0] i_wr_data,
  input  addr_t                   i_wr_base,
  input  logic [c_WB-1:0]         i_wr_off,
  input  logic [c_LB-1:0]         i_head_line,
  output logic [c_WB-1:0]         o_head_off,
  input  logic [ISSUE*c_PW-1:0]   i_rd_ptr,
  output logic [32*ISSUE-1:0]     o_rd_word,
  output logic [32*ISSUE-1:0]     o_rd_pc
);
  word_t           r_data [DEPTH][LINE_WORDS];
  addr_t           r_base [DEPTH];
  logic [c_WB-1:0] r_off  [DEPTH];

  // Payload storage needs no reset: slot validity is owned by the queue logic.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      for (int w = 0; w < LINE_WORDS; w++) begin
        r_data[i_wr_line][w] <= i_wr_data[32*w +: 32];
      end
      r_base[i_wr_line] <= i_wr_base;
      r_off[i_wr_line]  <= i_wr_off;
    end
  end

  assign o_head_off = r_off[i_head_line];

  for (genvar k = 0; k < ISSUE; k++) begin : g_rd
    logic [c_LB-1:0] w_line;
    logic [c_WB-1:0] w_word;
    assign {w_line, w_word}      = i_rd_ptr[k*c_PW +: c_PW];
    assign o_rd_word[32*k +: 32] = r_data[w_line][w_word];
    assign o_rd_pc[32*k +: 32]   = r_base[w_line] + addr_t'({w_word, 2'b00});
  end
endmodule
`default_nettype wire

// File: rtl/ifq_wide.sv
`default_nettype none
// ============================================================================
// Module : ifq_wide
// Brief  : Line-wide instruction fetch queue presenting up to ISSUE words/cycle.
// Rev    : 1.0
// ============================================================================
module ifq_wide
  import ifq_pkg::*;
#(
  parameter int          LINE_WORDS = c_LINE_WORDS,
  parameter int          DEPTH      = c_DEPTH,
  parameter int          ISSUE      = c_ISSUE,
  parameter logic [31:0] RESET_PC   = c_RESET_PC,
  localparam int c_CW = $clog2(ISSUE + 1)
)(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     d_valid,
  input  logic [32*LINE_WORDS-1:0] mem_data,
  output logic                     m_rd_en,
  output addr_t                    mem_addr,
  output logic                     abort,
  input  logic                     jump_branch_valid,
  input  addr_t                    jump_branch_add,
  input  logic [c_CW-1:0]          d_rd_cnt,
  output logic                     empty,
  output logic [c_CW-1:0]          avail_cnt,
  output logic [ISSUE-1:0]         i_valid,
  output logic [32*ISSUE-1:0]      i_code,
  output logic [32*ISSUE-1:0]      pc_out
);
  localparam int    c_WB         = $clog2(LINE_WORDS);
  localparam int    c_LB         = $clog2(DEPTH);
  localparam int    c_PW         = c_LB + c_WB;
  localparam int    c_FW         = $clog2(DEPTH + 1);
  localparam int    c_NW         = $clog2(DEPTH * LINE_WORDS + 1);
  localparam addr_t c_LINE_BYTES = addr_t'(4 * LINE_WORDS);
  localparam addr_t c_LINE_MASK  = ~(c_LINE_BYTES - addr_t'(1));

  addr_t           r_fetch_pc;
  logic [c_WB-1:0] r_next_off;
  logic [c_FW-1:0] r_filled;
  logic [c_LB-1:0] r_tail;
  logic [c_PW-1:0] r_head;

  logic [c_WB-1:0]       w_head_off;
  logic [c_WB-1:0]       w_eff_word;
  logic [c_PW-1:0]       w_eff_ptr;
  logic [c_NW-1:0]       w_words;
  logic [c_CW-1:0]       w_pop;
  logic [c_WB:0]         w_sum;
  logic                  w_cross;
  logic                  w_accept;
  logic [ISSUE*c_PW-1:0] w_rd_ptr;
  logic [32*ISSUE-1:0]   w_rd_word;
  logic [32*ISSUE-1:0]   w_rd_pc;

  // The first line after a redirect starts mid-line; its stored offset lifts the head.
  assign w_eff_word = (r_head[c_WB-1:0] > w_head_off) ? r_head[c_WB-1:0] : w_head_off;
  assign w_eff_ptr  = {r_head[c_PW-1:c_WB], w_eff_word};
  assign w_words    = (r_filled == '0) ? '0
                    : (c_NW'(r_filled) << c_WB) - c_NW'(w_eff_word);
  assign avail_cnt  = (w_words >= c_NW'(ISSUE)) ? c_CW'(ISSUE) : c_CW'(w_words);
  assign empty      = (avail_cnt == '0);
  assign w_pop      = (d_rd_cnt < avail_cnt) ? d_rd_cnt : avail_cnt;
  assign w_sum      = {1'b0, w_eff_word} + (c_WB+1)'(w_pop);
  assign w_cross    = w_sum[c_WB];

  // A request is outstanding whenever a line slot is free to reserve for it.
  assign m_rd_en  = ~rst & (r_filled < c_FW'(DEPTH));
  assign mem_addr = r_fetch_pc;
  assign abort    = jump_branch_valid & m_rd_en;
  assign w_accept = d_valid & m_rd_en & ~jump_branch_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC & c_LINE_MASK;
      r_next_off <= '0;
      r_filled   <= '0;
      r_tail     <= '0;
      r_head     <= '0;
    end else if (jump_branch_valid) begin
      r_fetch_pc <= jump_branch_add & c_LINE_MASK;
      r_next_off <= jump_branch_add[c_WB+1:2];
      r_filled   <= '0;
      r_head     <= {r_tail, {c_WB{1'b0}}};
    end else begin
      if (w_accept) begin
        r_fetch_pc <= r_fetch_pc + c_LINE_BYTES;
        r_next_off <= '0;
        r_tail     <= r_tail + 1'b1;
      end
      if (w_pop != '0) begin
        r_head <= {r_head[c_PW-1:c_WB] + c_LB'(w_cross), w_sum[c_WB-1:0]};
      end
      r_filled <= r_filled + c_FW'(w_accept) - c_FW'(w_cross);
    end
  end

  ifq_line_buf #(
    .LINE_WORDS (LINE_WORDS),
    .DEPTH      (DEPTH),
    .ISSUE      (ISSUE)
  ) u_buf (
    .clk         (clk),
    .i_wr_en     (w_accept),
    .i_wr_line   (r_tail),
    .i_wr_data   (mem_data),
    .i_wr_base   (r_fetch_pc),
    .i_wr_off    (r_next_off),
    .i_head_line (r_head[c_PW-1:c_WB]),
    .o_head_off  (w_head_off),
    .i_rd_ptr    (w_rd_ptr),
    .o_rd_word   (w_rd_word),
    .o_rd_pc     (w_rd_pc)
  );

  for (genvar k = 0; k < ISSUE; k++) begin : g_slot
    logic w_vld;
    assign w_rd_ptr[k*c_PW +: c_PW] = w_eff_ptr + c_PW'(k);
    assign w_vld                    = (avail_cnt > c_CW'(k));
    assign i_valid[k]               = w_vld;
    assign i_code[32*k +: 32]       = w_vld ? w_rd_word[32*k +: 32] : 32'h0;
    assign pc_out[32*k +: 32]       = w_vld ? w_rd_pc[32*k +: 32] : 32'h0;
  end
endmodule
`default_nettype wire

// File: tb/tb_ifq_wide.sv
`default_nettype none
// ============================================================================
// Module : tb_ifq_wide
// Brief  : Randomized and directed bench for ifq_wide against a word-queue model.
// Rev    : 1.0
// ============================================================================
module tb_ifq_wide;
  import ifq_pkg::*;

  localparam int          LW  = 4;
  localparam int          DP  = 4;
  localparam int          IS  = 2;
  localparam logic [31:0] RPC = 32'h0040_0000;
  localparam int          CW  = $clog2(IS + 1);

  logic                clk = 1'b0;
  logic                rst;
  logic                d_valid;
  logic [32*LW-1:0]    mem_data;
  logic                m_rd_en;
  logic [31:0]         mem_addr;
  logic                abort;
  logic                jump_branch_valid;
  logic [31:0]         jump_branch_add;
  logic [CW-1:0]       d_rd_cnt;
  logic                empty;
  logic [CW-1:0]       avail_cnt;
  logic [IS-1:0]       i_valid;
  logic [32*IS-1:0]    i_code;
  logic [32*IS-1:0]    pc_out;

  always #5 clk = ~clk;

  ifq_wide #(
    .LINE_WORDS (LW),
    .DEPTH      (DP),
    .ISSUE      (IS),
    .RESET_PC   (RPC)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .d_valid           (d_valid),
    .mem_data          (mem_data),
    .m_rd_en           (m_rd_en),
    .mem_addr          (mem_addr),
    .abort             (abort),
    .jump_branch_valid (jump_branch_valid),
    .jump_branch_add   (jump_branch_add),
    .d_rd_cnt          (d_rd_cnt),
    .empty             (empty),
    .avail_cnt         (avail_cnt),
    .i_valid           (i_valid),
    .i_code            (i_code),
    .pc_out            (pc_out)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: flat queue of words with their PCs, plus remaining words per line.
  logic [31:0] m_word[$];
  logic [31:0] m_pc[$];
  int          m_line[$];
  logic [31:0] m_fetch;
  int          m_off;

  function automatic int m_avail();
    return (m_word.size() < IS) ? m_word.size() : IS;
  endfunction

  function automatic bit m_req();
    return m_line.size() < DP;
  endfunction

  task automatic model_reset();
    m_word.delete();
    m_pc.delete();
    m_line.delete();
    m_fetch = RPC & ~32'(4*LW - 1);
    m_off   = 0;
  endtask

  function automatic logic [32*LW-1:0] rand_line();
    logic [32*LW-1:0] l;
    for (int w = 0; w < LW; w++) l[32*w +: 32] = $urandom;
    return l;
  endfunction

  task automatic check_outputs();
    logic [32*IS-1:0] ec;
    logic [32*IS-1:0] ep;
    logic [IS-1:0]    ev;
    ec = '0;
    ep = '0;
    ev = '0;
    for (int k = 0; k < IS; k++) begin
      if (k < m_avail()) begin
        ev[k]         = 1'b1;
        ec[32*k +: 32] = m_word[k];
        ep[32*k +: 32] = m_pc[k];
      end
    end
    chk("m_rd_en",   64'(m_rd_en),   64'(m_req()));
    chk("mem_addr",  64'(mem_addr),  64'(m_fetch));
    chk("empty",     64'(empty),     64'(m_word.size() == 0));
    chk("avail_cnt", 64'(avail_cnt), 64'(m_avail()));
    chk("i_valid",   64'(i_valid),   64'(ev));
    chk("i_code",    64'(i_code),    64'(ec));
    chk("pc_out",    64'(pc_out),    64'(ep));
  endtask

  // Drive one cycle of inputs (from a negedge), advance the model, check after the edge.
  task automatic step(input bit dv, input logic [32*LW-1:0] data, input bit jv,
                      input logic [31:0] tgt, input int rd);
    int n;
    bit req;
    d_valid           = dv;
    mem_data          = data;
    jump_branch_valid = jv;
    jump_branch_add   = tgt;
    d_rd_cnt          = CW'(rd);
    #1;
    req = m_req();
    chk("abort", 64'(abort), 64'(jv && req));
    @(posedge clk);
    if (jv) begin
      m_word.delete();
      m_pc.delete();
      m_line.delete();
      m_fetch = tgt & ~32'(4*LW - 1);
      m_off   = int'((tgt >> 2) % LW);
    end else begin
      n = (rd < m_avail()) ? rd : m_avail();
      repeat (n) begin
        void'(m_word.pop_front());
        void'(m_pc.pop_front());
        m_line[0] = m_line[0] - 1;
        if (m_line[0] == 0) void'(m_line.pop_front());
      end
      if (dv && req) begin
        for (int w = m_off; w < LW; w++) begin
          m_word.push_back(data[32*w +: 32]);
          m_pc.push_back(m_fetch + 32'(4*w));
        end
        m_line.push_back(LW - m_off);
        m_fetch = m_fetch + 32'(4*LW);
        m_off   = 0;
      end
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic check_reset_state(input string ph);
    chk({ph, "_m_rd_en"},   64'(m_rd_en),   64'(0));
    chk({ph, "_abort"},     64'(abort),     64'(0));
    chk({ph, "_empty"},     64'(empty),     64'(1));
    chk({ph, "_avail_cnt"}, 64'(avail_cnt), 64'(0));
    chk({ph, "_i_valid"},   64'(i_valid),   64'(0));
    chk({ph, "_i_code"},    64'(i_code),    64'(0));
    chk({ph, "_pc_out"},    64'(pc_out),    64'(0));
    chk({ph, "_mem_addr"},  64'(mem_addr),  64'(RPC));
  endtask

  task automatic release_reset();
    d_valid           = 1'b0;
    jump_branch_valid = 1'b0;
    d_rd_cnt          = '0;
    rst               = 1'b0;
    #1;
    chk("post_rst_m_rd_en",  64'(m_rd_en),  64'(1));
    chk("post_rst_mem_addr", 64'(mem_addr), 64'(RPC));
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    bit          dv;
    bit          jv;
    int          rd;
    logic [31:0] tgt;

    rst               = 1'b1;
    d_valid           = 1'b0;
    mem_data          = '0;
    jump_branch_valid = 1'b0;
    jump_branch_add   = '0;
    d_rd_cnt          = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    release_reset();

    // First line lands, request advances to the next line.
    step(1, rand_line(), 0, 32'h0, 0);
    chk("first_avail", 64'(avail_cnt), 64'(2));
    chk("first_pc",    64'(pc_out),    {32'h0040_0004, 32'h0040_0000});
    chk("first_addr",  64'(mem_addr),  64'(32'h0040_0010));

    // Fill to DEPTH, then free one line with two pops of two.
    repeat (3) step(1, rand_line(), 0, 32'h0, 0);
    chk("full_m_rd_en", 64'(m_rd_en), 64'(0));
    step(1, rand_line(), 0, 32'h0, 0);
    step(0, '0, 0, 32'h0, 2);
    step(0, '0, 0, 32'h0, 2);
    chk("freed_m_rd_en", 64'(m_rd_en),  64'(1));
    chk("freed_addr",    64'(mem_addr), 64'(32'h0040_0040));

    // Redirect into the middle of a line while a request is outstanding.
    step(0, '0, 1, 32'h0040_001C, 0);
    chk("redir_empty", 64'(empty),    64'(1));
    chk("redir_addr",  64'(mem_addr), 64'(32'h0040_0010));
    step(1, rand_line(), 0, 32'h0, 0);
    chk("redir_avail", 64'(avail_cnt),     64'(1));
    chk("redir_pc0",   64'(pc_out[31:0]),  64'(32'h0040_001C));
    chk("redir_next",  64'(mem_addr),      64'(32'h0040_0020));

    // Head at last word of a line: slots span into the following line.
    step(0, '0, 1, 32'h0040_000C, 0);
    step(1, rand_line(), 0, 32'h0, 0);
    step(1, rand_line(), 0, 32'h0, 0);
    chk("span_pc", 64'(pc_out), {32'h0040_0010, 32'h0040_000C});
    step(0, '0, 0, 32'h0, 2);
    chk("span_head", 64'(pc_out[31:0]), 64'(32'h0040_0014));

    // Redirect wins over a returning line and a pop in the same cycle.
    step(1, rand_line(), 1, 32'h0040_0100, 2);
    chk("collide_empty", 64'(empty), 64'(1));
    step(0, '0, 0, 32'h0, 0);

    // Fetch address wraps past the top of memory.
    step(0, '0, 1, 32'hFFFF_FFF4, 0);
    step(1, rand_line(), 0, 32'h0, 0);
    step(1, rand_line(), 0, 32'h0, 0);
    chk("wrap_addr", 64'(mem_addr), 64'(32'h0000_0010));

    // Reset with lines queued and a request outstanding.
    step(0, '0, 1, 32'h0040_0200, 0);
    repeat (3) step(1, rand_line(), 0, 32'h0, 0);
    rst               = 1'b1;
    jump_branch_valid = 1'b1;
    d_valid           = 1'b1;
    #1;
    check_reset_state("midrst");
    @(posedge clk);
    @(negedge clk);
    check_reset_state("midrst_hold");
    model_reset();
    release_reset();

    // Randomized traffic, including stray returns and occasional redirects.
    for (int c = 0; c < 1500; c++) begin
      dv = ($urandom_range(0, 99) < 60);
      jv = ($urandom_range(0, 99) < 4);
      rd = int'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFE0 + 32'(4 * $urandom_range(0, 7));
      else                           tgt = RPC + 32'(4 * $urandom_range(0, 63));
      step(dv, rand_line(), jv, tgt, rd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/ifq_wide.md
IFQ_WIDE -- requirements
Module: ifq_wide

Interface
REQ-001 SHALL have parameter LINE_WORDS, default 4, 32-bit instruction words per fetch line (power of two, >=2).
REQ-002 SHALL have parameter DEPTH, default 4, line entries stored (power of two, >=2).
REQ-003 SHALL have parameter ISSUE, default 2, max instructions presented/popped per cycle (1..LINE_WORDS).
REQ-004 SHALL have parameter RESET_PC, default 32'h0040_0000, first fetch address.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-high.
REQ-007 d_valid  input  1  memory returns line on mem_data this cycle.
REQ-008 mem_data  input  32*LINE_WORDS  fetched line, word 0 in bits [31:0].
REQ-009 m_rd_en  output  1  line request valid.
REQ-010 mem_addr  output  32  line-aligned request address.
REQ-011 abort  output  1  one-cycle pulse cancelling outstanding request.
REQ-012 jump_branch_valid  input  1  redirect request.
REQ-013 jump_branch_add  input  32  redirect target (word-aligned).
REQ-014 d_rd_cnt  input  clog2(ISSUE+1)  instructions consumed this cycle.
REQ-015 empty  output  1  no valid instruction at head.
REQ-016 avail_cnt  output  clog2(ISSUE+1)  min(valid words queued, ISSUE).
REQ-017 i_valid  output  ISSUE  slot k valid iff k < avail_cnt.
REQ-018 i_code  output  32*ISSUE  slot k = k-th word from head; zero when slot invalid.
REQ-019 pc_out  output  32*ISSUE  address of slot k; zero when slot invalid.

Function
REQ-020 Request handshake: m_rd_en asserted when no request outstanding-complete conflict and lines_used < DEPTH; once asserted, m_rd_en and mem_addr hold until d_valid or redirect.
REQ-021 One outstanding request max; fetch line reserved at request time (lines_used counts it).
REQ-022 d_valid while request outstanding: line written to tail, fetch_pc += 4*LINE_WORDS (mod 2^32); data visible on outputs next cycle; new request may issue same next cycle.
REQ-023 d_valid with no outstanding request SHALL be ignored.
REQ-024 Pop: head word pointer advances by min(d_rd_cnt, avail_cnt); line freed when pointer crosses line end; slots SHALL span two lines when head near line end.
REQ-025 Redirect (jump_branch_valid=1): next cycle queue empty, fetch_pc = target & ~(4*LINE_WORDS-1), first new line's start offset = target word index; words below offset invalid.
REQ-026 Redirect with request outstanding: abort=1 for that cycle; else abort=0.
REQ-027 Redirect same cycle as d_valid and/or pop: redirect wins; returned line dropped, pop ignored.
REQ-028 Full (DEPTH lines incl. reserved): m_rd_en=0 until a line frees; pop in full cycle enables request next cycle.
REQ-029 Pointer wrap: line pointers modulo DEPTH, fetch_pc wraps 0xFFFF_FFF0->0x0000_0000 without error.

Reset
REQ-030 While rst=1: queue empty, fetch_pc=RESET_PC, start offset 0, m_rd_en=0, abort=0, empty=1, avail_cnt=0, i_valid=0, i_code=0, pc_out=0.
REQ-031 First cycle after rst deasserts: m_rd_en=1, mem_addr=RESET_PC aligned.
REQ-032 Reset mid-request SHALL discard outstanding request without abort pulse.

Structure
REQ-033 Package ifq_pkg SHALL hold default LINE_WORDS/DEPTH/ISSUE/RESET_PC, word_t and addr_t typedefs.
REQ-034 Line storage SHALL be sub-module ifq_line_buf: one line write port, ISSUE word read ports at arbitrary word pointer, per-line base PC and start offset.

Verification (LINE_WORDS=4, DEPTH=4, ISSUE=2, RESET_PC=0x00400000)
REQ-035 Release rst; d_valid with words A0..A3 -> next cycle avail_cnt=2, pc_out={0x00400004,0x00400000}, mem_addr=0x00400010.
REQ-036 d_rd_cnt=0, return 4 lines -> m_rd_en=0; pop 2 twice -> m_rd_en=1 next cycle, mem_addr=0x00400040.
REQ-037 Redirect to 0x0040001C with request outstanding -> abort=1 one cycle, empty=1 next cycle, mem_addr=0x00400010; line returns -> avail_cnt=1, pc_out slot0=0x0040001C; next mem_addr=0x00400020.
REQ-038 Head at 0x0040000C, next line present, d_rd_cnt=2 -> pc_out slots 0x0040000C,0x00400010, then head 0x00400014.
REQ-039 Redirect, d_valid and d_rd_cnt=2 same cycle -> line dropped, empty=1, queued words lost.
REQ-040 Assert rst with 3 lines queued and request outstanding -> all outputs per REQ-030, abort=0, refetch from 0x00400000.
